// File: rtl/noc_pkt_injector_if.sv
// noc_pkt_injector_if
//   Bundles the two handshake channels of the packet injector:
//   - command channel : cmd_valid/cmd_ready plus cmd_dest, cmd_class,
//                       cmd_len (flits incl. header), cmd_seed
//   - link channel    : out_flit/out_last/out_valid/out_ready
//   modport master : the injector (consumes commands, drives the link)
//   modport slave  : the environment (issues commands, sinks the link)
interface noc_pkt_injector_if #(
  parameter int FLIT_WIDTH  = 32,
  parameter int DEST_WIDTH  = 5,
  parameter int CLASS_WIDTH = 3,
  parameter int MAX_LEN     = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [DEST_WIDTH-1:0]  cmd_dest;
  logic [CLASS_WIDTH-1:0] cmd_class;
  logic [LEN_W-1:0]       cmd_len;
  logic [FLIT_WIDTH-1:0]  cmd_seed;

  logic [FLIT_WIDTH-1:0]  out_flit;
  logic                   out_last;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    input  cmd_valid, cmd_dest, cmd_class, cmd_len, cmd_seed, out_ready,
    output cmd_ready, out_flit, out_last, out_valid
  );

  modport slave (
    output cmd_valid, cmd_dest, cmd_class, cmd_len, cmd_seed, out_ready,
    input  cmd_ready, out_flit, out_last, out_valid
  );
endinterface

// File: rtl/noc_pkt_injector.sv
// noc_pkt_injector
//   Simulation-side NoC packet source. Accepts one command at a time,
//   emits a header flit followed by len-1 payload flits (seed, seed+1, ...)
//   on a valid/ready link, then optionally idles GAP cycles.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : noc_pkt_injector_if.master (command + link channels)
//   busy       : packet in progress or post-packet gap running
//   err        : one-cycle pulse when a command with illegal length is dropped
//   pkt_count  : packets whose last flit has transferred (wraps)
module noc_pkt_injector #(
  parameter int FLIT_WIDTH  = 32,
  parameter int DEST_WIDTH  = 5,
  parameter int CLASS_WIDTH = 3,
  parameter int SRC_WIDTH   = 5,
  parameter int SRC_ID      = 0,
  parameter int MAX_LEN     = 8,
  parameter int GAP         = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  noc_pkt_injector_if.master   bus,
  output logic                 busy,
  output logic                 err,
  output logic [15:0]          pkt_count
);

  localparam int LEN_W    = $clog2(MAX_LEN + 1);
  localparam int HDR_BITS = DEST_WIDTH + CLASS_WIDTH + SRC_WIDTH;
  localparam int GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [SRC_WIDTH-1:0] SRC_VAL  = SRC_WIDTH'(SRC_ID);
  localparam logic [LEN_W-1:0]     LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]     LEN_ONE  = LEN_W'(1);
  // WAIT lasts GAP cycles: the counter is loaded with GAP-1 and the
  // state leaves WAIT in the cycle the counter reads zero.
  localparam logic [GAP_W-1:0]     GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAY, ST_WAIT} state_t;

  state_t                 state_reg, state_next;
  logic [DEST_WIDTH-1:0]  dest_reg,  dest_next;
  logic [CLASS_WIDTH-1:0] class_reg, class_next;
  logic [LEN_W-1:0]       len_reg,   len_next;
  logic [LEN_W-1:0]       idx_reg,   idx_next;   // flit index within packet, 0 = header
  logic [FLIT_WIDTH-1:0]  pay_reg,   pay_next;   // current payload value
  logic [GAP_W-1:0]       gap_reg,   gap_next;
  logic                   err_reg,   err_next;
  logic [15:0]            cnt_reg,   cnt_next;

  logic                   cmd_ready_c;
  logic                   out_valid_c;
  logic                   out_last_c;
  logic [FLIT_WIDTH-1:0]  out_flit_c;
  logic [FLIT_WIDTH-1:0]  header_c;
  logic                   len_bad_c;

  // Header: dest in the top bits, then class, then source, zeros below.
  assign header_c  = FLIT_WIDTH'({dest_reg, class_reg, SRC_VAL}) << (FLIT_WIDTH - HDR_BITS);
  assign len_bad_c = (bus.cmd_len == '0) || (bus.cmd_len > LEN_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      dest_reg  <= '0;
      class_reg <= '0;
      len_reg   <= '0;
      idx_reg   <= '0;
      pay_reg   <= '0;
      gap_reg   <= '0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      dest_reg  <= dest_next;
      class_reg <= class_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
      pay_reg   <= pay_next;
      gap_reg   <= gap_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    dest_next   = dest_reg;
    class_next  = class_reg;
    len_next    = len_reg;
    idx_next    = idx_reg;
    pay_next    = pay_reg;
    gap_next    = gap_reg;
    err_next    = 1'b0;
    cnt_next    = cnt_reg;
    cmd_ready_c = 1'b0;
    out_valid_c = 1'b0;
    out_last_c  = 1'b0;
    out_flit_c  = '0;

    case (state_reg)
      ST_IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) begin
          if (len_bad_c) begin
            // Command is consumed but produces no traffic.
            err_next = 1'b1;
          end else begin
            dest_next  = bus.cmd_dest;
            class_next = bus.cmd_class;
            len_next   = bus.cmd_len;
            pay_next   = bus.cmd_seed;
            idx_next   = '0;
            state_next = ST_HDR;
          end
        end
      end

      ST_HDR, ST_PAY: begin
        out_valid_c = 1'b1;
        out_last_c  = (idx_reg == len_reg - LEN_ONE);
        out_flit_c  = (state_reg == ST_HDR) ? header_c : pay_reg;
        if (bus.out_ready) begin
          if (out_last_c) begin
            cnt_next = cnt_reg + 16'd1;
            if (GAP == 0) begin
              state_next = ST_IDLE;
            end else begin
              gap_next   = GAP_LOAD;
              state_next = ST_WAIT;
            end
          end else begin
            idx_next   = idx_reg + LEN_ONE;
            state_next = ST_PAY;
            // The header transfer does not consume a payload value.
            if (state_reg == ST_PAY) begin
              pay_next = pay_reg + 1'b1;
            end
          end
        end
      end

      ST_WAIT: begin
        if (gap_reg == '0) begin
          state_next = ST_IDLE;
        end else begin
          gap_next = gap_reg - 1'b1;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_last_c;
  assign bus.out_flit  = out_flit_c;
  assign busy          = (state_reg != ST_IDLE);
  assign err           = err_reg;
  assign pkt_count     = cnt_reg;

endmodule

// File: tb/tb_noc_pkt_injector.sv
module tb_noc_pkt_injector;

  logic clk;
  logic rst;

  logic        busy0, err0, busy3, err3;
  logic [15:0] cnt0, cnt3;

  int checks = 0;
  int errors = 0;
  int xfer0  = 0;
  int base;

  noc_pkt_injector_if #(.FLIT_WIDTH(32), .DEST_WIDTH(5), .CLASS_WIDTH(3), .MAX_LEN(8)) b0 ();
  noc_pkt_injector_if #(.FLIT_WIDTH(32), .DEST_WIDTH(5), .CLASS_WIDTH(3), .MAX_LEN(8)) b3 ();

  // GAP=0 instance, SRC_ID=5 -> source field contributes 0x00280000
  noc_pkt_injector #(.FLIT_WIDTH(32), .DEST_WIDTH(5), .CLASS_WIDTH(3), .SRC_WIDTH(5),
                     .SRC_ID(5), .MAX_LEN(8), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0), .busy(busy0), .err(err0), .pkt_count(cnt0));

  // GAP=3 instance, SRC_ID=2 -> source field contributes 0x00100000
  noc_pkt_injector #(.FLIT_WIDTH(32), .DEST_WIDTH(5), .CLASS_WIDTH(3), .SRC_WIDTH(5),
                     .SRC_ID(2), .MAX_LEN(8), .GAP(3)) dut3 (
    .clk(clk), .rst(rst), .bus(b3), .busy(busy3), .err(err3), .pkt_count(cnt3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One line per link transfer.
  always @(posedge clk) begin
    if (!rst && b0.out_valid && b0.out_ready) begin
      xfer0 <= xfer0 + 1;
      $display("%0t dut0 xfer flit=0x%08h last=%0b", $time, b0.out_flit, b0.out_last);
    end
    if (!rst && b3.out_valid && b3.out_ready)
      $display("%0t dut3 xfer flit=0x%08h last=%0b", $time, b3.out_flit, b3.out_last);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command on dut0 in the current cycle (it is IDLE, so accepted).
  task automatic cmd0(input logic [4:0] d, input logic [2:0] c, input logic [3:0] l,
                      input logic [31:0] s);
    check("cmd_ready0", b0.cmd_ready, 1);
    b0.cmd_valid = 1'b1;
    b0.cmd_dest  = d;
    b0.cmd_class = c;
    b0.cmd_len   = l;
    b0.cmd_seed  = s;
    tick();
    // Scramble the command inputs: the packet in flight must not notice.
    b0.cmd_valid = 1'b0;
    b0.cmd_dest  = 5'h1F;
    b0.cmd_class = 3'h7;
    b0.cmd_len   = 4'd0;
    b0.cmd_seed  = 32'hDEAD_BEEF;
  endtask

  // Check the flit visible this cycle on dut0, then advance one cycle.
  task automatic flit0(input string tag, input logic [31:0] f, input logic l);
    check({tag, "_valid"}, b0.out_valid, 1);
    check({tag, "_flit"},  b0.out_flit,  f);
    check({tag, "_last"},  b0.out_last,  l);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    b0.cmd_valid = 0; b0.cmd_dest = 0; b0.cmd_class = 0; b0.cmd_len = 0; b0.cmd_seed = 0;
    b0.out_ready = 1;
    b3.cmd_valid = 0; b3.cmd_dest = 0; b3.cmd_class = 0; b3.cmd_len = 0; b3.cmd_seed = 0;
    b3.out_ready = 1;
    repeat (3) tick();
    check("rst_valid", b0.out_valid, 0);
    check("rst_flit",  b0.out_flit, 0);
    check("rst_busy",  busy0, 0);
    check("rst_err",   err0, 0);
    check("rst_cnt",   cnt0, 0);
    check("rst_ready", b0.cmd_ready, 1);
    rst = 1'b0;
    tick();

    // Single packet: dest=3 class=1 len=4 seed=0x100
    cmd0(5'd3, 3'd1, 4'd4, 32'h100);
    check("p1_busy", busy0, 1);
    flit0("p1_hdr", 32'h1928_0000, 0);
    flit0("p1_pl1", 32'h0000_0100, 0);
    flit0("p1_pl2", 32'h0000_0101, 0);
    check("p1_cnt_before", cnt0, 0);
    flit0("p1_pl3", 32'h0000_0102, 1);
    check("p1_valid_after", b0.out_valid, 0);
    check("p1_cnt", cnt0, 1);
    check("p1_busy_after", busy0, 0);

    // Back-to-back with backpressure: dest=7 class=2 len=3 seed=0x200.
    // Offered at M+1; header must appear at M+2 at the earliest.
    base = xfer0;
    cmd0(5'd7, 3'd2, 4'd3, 32'h200);
    flit0("p2_hdr", 32'h3A28_0000, 0);
    b0.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", b0.out_valid, 1);
      check("bp_flit",  b0.out_flit, 32'h200);
      check("bp_last",  b0.out_last, 0);
      tick();
    end
    b0.out_ready = 1'b1;
    flit0("p2_pl1", 32'h0000_0200, 0);
    flit0("p2_pl2", 32'h0000_0201, 1);
    check("p2_xfers", xfer0 - base, 3);
    check("p2_cnt", cnt0, 2);

    // Single-flit packet: dest=0 class=7 len=1
    cmd0(5'd0, 3'd7, 4'd1, 32'h1234);
    flit0("p3_hdr", 32'h0728_0000, 1);
    check("p3_valid_after", b0.out_valid, 0);
    check("p3_cnt", cnt0, 3);

    // Payload wrap: dest=2 class=3 len=3 seed=0xFFFFFFFF
    cmd0(5'd2, 3'd3, 4'd3, 32'hFFFF_FFFF);
    flit0("p4_hdr", 32'h1328_0000, 0);
    flit0("p4_pl1", 32'hFFFF_FFFF, 0);
    flit0("p4_pl2", 32'h0000_0000, 1);
    check("p4_cnt", cnt0, 4);

    // Illegal lengths 0 and MAX_LEN+1
    cmd0(5'd1, 3'd1, 4'd0, 32'h0);
    check("il0_err",   err0, 1);
    check("il0_valid", b0.out_valid, 0);
    check("il0_busy",  busy0, 0);
    tick();
    check("il0_err_clr", err0, 0);
    cmd0(5'd1, 3'd1, 4'd9, 32'h0);
    check("il9_err",   err0, 1);
    check("il9_valid", b0.out_valid, 0);
    tick();
    check("il9_err_clr", err0, 0);
    check("il9_valid2", b0.out_valid, 0);
    check("il_cnt", cnt0, 4);

    // Maximum length: dest=1 class=0 len=8 seed=0x10
    cmd0(5'd1, 3'd0, 4'd8, 32'h10);
    flit0("p5_hdr", 32'h0828_0000, 0);
    for (int k = 1; k < 8; k++)
      flit0("p5_pl", 32'h10 + 32'(k - 1), (k == 7));
    check("p5_cnt", cnt0, 5);

    // GAP=3 instance with two queued commands.
    check("g_ready0", b3.cmd_ready, 1);
    b3.cmd_valid = 1; b3.cmd_dest = 5'd4; b3.cmd_class = 3'd0; b3.cmd_len = 4'd2;
    b3.cmd_seed = 32'h7;
    tick();
    // Second command waits on the interface.
    b3.cmd_dest = 5'd1; b3.cmd_class = 3'd5; b3.cmd_len = 4'd1; b3.cmd_seed = 32'h0;
    check("g_hdr_flit", b3.out_flit, 32'h2010_0000);
    check("g_hdr_ready", b3.cmd_ready, 0);
    check("g_hdr_busy", busy3, 1);
    tick();
    check("g_pl_flit", b3.out_flit, 32'h7);
    check("g_pl_last", b3.out_last, 1);
    tick();   // M+1
    for (int i = 1; i <= 3; i++) begin
      check("g_wait_ready", b3.cmd_ready, 0);
      check("g_wait_busy",  busy3, 1);
      check("g_wait_valid", b3.out_valid, 0);
      if (i < 3) tick();
    end
    tick();   // M+4
    check("g_ready_rise", b3.cmd_ready, 1);
    check("g_cnt1", cnt3, 1);
    tick();
    b3.cmd_valid = 0;
    check("g_hdr2_flit", b3.out_flit, 32'h0D10_0000);
    check("g_hdr2_last", b3.out_last, 1);
    tick();
    check("g_cnt2", cnt3, 2);
    check("g_busy2", busy3, 1);

    // Reset during the second payload flit.
    cmd0(5'd3, 3'd1, 4'd4, 32'h300);
    flit0("r_hdr", 32'h1928_0000, 0);
    flit0("r_pl1", 32'h0000_0300, 0);
    check("r_pl2_flit", b0.out_flit, 32'h301);
    rst = 1'b1;
    #1;
    check("r_valid", b0.out_valid, 0);
    check("r_cnt",   cnt0, 0);
    check("r_busy",  busy0, 0);
    check("r_last",  b0.out_last, 0);
    tick();
    rst = 1'b0;
    tick();
    cmd0(5'd3, 3'd1, 4'd2, 32'h40);
    flit0("r2_hdr", 32'h1928_0000, 0);
    flit0("r2_pl1", 32'h0000_0040, 1);
    check("r2_cnt", cnt0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_pkt_injector.md
Name: noc_pkt_injector

Overview:
Testbench-side NoC packet source, the transmit-side counterpart of the link tracer/monitor. It accepts packet commands (destination, class, length, payload seed), formats a header flit plus pattern payload, and drives one NoC link channel over flit/last/valid/ready. It is used in system simulations to inject directed traffic into a tile's link-in port; it contains no memory beyond the current command.

Parameters:
FLIT_WIDTH, 32, flit data width
DEST_WIDTH, 5, destination field width in header
CLASS_WIDTH, 3, packet class field width
SRC_WIDTH, 5, source field width
SRC_ID, 0, source tile ID placed in header
MAX_LEN, 8, maximum packet length in flits (header included), >=1
GAP, 0, idle cycles enforced after each packet's last flit before next command accepted

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_dest  in  DEST_WIDTH  destination tile
cmd_class  in  CLASS_WIDTH  packet class
cmd_len  in  clog2(MAX_LEN+1)  packet length in flits incl. header
cmd_seed  in  FLIT_WIDTH  payload pattern seed
out_flit  out  FLIT_WIDTH  flit data
out_last  out  1  final flit of packet
out_valid  out  1  flit valid
out_ready  in  1  sink ready
busy  out  1  packet in progress or gap running
err  out  1  one-cycle pulse: illegal length rejected
pkt_count  out  16  packets fully sent, wraps at 2^16

Behaviour:
- Reset (async, active-high): state IDLE; out_flit=0, out_last=0, out_valid=0, busy=0, err=0, pkt_count=0. cmd_ready = (state==IDLE), so it is 1 while in reset; the bench must not offer commands during reset.
- States: IDLE, HDR, PAY, WAIT.
- IDLE: cmd_ready=1. Command accepted at cycle N with 1<=cmd_len<=MAX_LEN: latch the fields, go to HDR. out_valid=1 with the header flit from cycle N+1.
- Illegal length (cmd_len==0 or >MAX_LEN): command is consumed, err=1 in cycle N+1 only, state stays IDLE, no flits, pkt_count unchanged.
- Header flit: [FW-1 -: DEST_WIDTH]=dest, next CLASS_WIDTH bits=class, next SRC_WIDTH bits=SRC_ID, remaining bits 0. out_last=1 if len==1.
- Payload flit k (k=1..len-1) = cmd_seed + (k-1), modulo 2^FLIT_WIDTH (wraps). out_last=1 on k=len-1.
- Handshake: a flit transfers on out_valid & out_ready. While out_valid=1 and out_ready=0, out_flit/out_last hold stable and out_valid stays 1. The next flit appears the cycle after the transfer. With out_ready held 1, throughput is 1 flit/cycle within a packet.
- On last-flit transfer at cycle M: pkt_count increments (visible at M+1), out_valid=0 at M+1. If GAP==0, go IDLE (cmd_ready=1 at M+1). Otherwise go WAIT for exactly GAP cycles, then IDLE (cmd_ready=1 at M+1+GAP).
- Back-to-back packets with GAP=0: at least one bubble cycle between packets (next header no earlier than M+2).
- busy=1 in HDR, PAY, WAIT; 0 in IDLE.
- Changes on cmd_* inputs after acceptance have no effect on the packet in flight.
- Reset mid-packet: outputs return to reset values immediately and the packet is abandoned (no last is emitted). After reset release, the next command starts a fresh header.

Test Plan:
- Single packet: GAP=0, dest=3, class=1, len=4, seed=0x100, out_ready=1 -> header {3,1,SRC_ID,0} at N+1, then 0x100, 0x101, 0x102 with last on 0x102; pkt_count=1.
- Backpressure: len=3, out_ready low for 5 cycles on the 2nd flit -> flit and last held stable, valid held; exactly 3 transfers total, in order.
- Single-flit and wrap: len=1 -> header with last=1. Then len=3, seed=0xFFFFFFFF -> payload 0xFFFFFFFF, 0x00000000.
- Illegal length: cmd_len=0, then cmd_len=MAX_LEN+1 -> err pulses 1 cycle each, no out_valid, pkt_count unchanged.
- Gap: GAP=3, two queued commands -> cmd_ready rises exactly 4 cycles after the first last-flit transfer; busy high throughout.
- Reset mid-packet: assert rst during the 2nd payload flit -> out_valid=0 immediately and pkt_count=0. A new command after release emits a correct header.
